// File: rtl/sha3_pkg.sv
// Shared types, rho offsets and lane helpers for the inverse rho-pi block.
package sha3_pkg;

   typedef logic [63:0] lane_t;
   typedef lane_t [4:0] row_t;
   typedef row_t  [4:0] state_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BUSY,
      ST_DONE
   } state_e;

   // Forward rho offsets, indexed [row a][lane b].
   localparam int RHO_OFFSET [5][5] = '{
      '{ 0,  1, 62, 28, 27},
      '{36, 44,  6, 55, 20},
      '{ 3, 10, 43, 25, 39},
      '{41, 45, 15, 21,  8},
      '{18,  2, 61, 56, 14}
   };

   function automatic logic [2:0] inv_pi_src_row(input int a, input int b);
      return 3'((2 * (b - a) + 10) % 5);
   endfunction

   function automatic lane_t rotr(input lane_t x, input int n);
      logic [127:0] t;
      t = {x, x} >> n;
      return t[63:0];
   endfunction

endpackage

// File: rtl/sha3_inv_rho_pi_row.sv
// One output row of inverse rho-pi: all rotations are constant, so this
// reduces to wiring plus a 5-way row select.
module sha3_inv_rho_pi_row
   import sha3_pkg::*;
(
   input  state_t     i_state,
   input  logic [2:0] i_row,
   output row_t       o_lanes
);

   always_comb begin
      o_lanes = '0;
      for (int a = 0; a < 5; a++) begin
         if (i_row == 3'(a)) begin
            for (int b = 0; b < 5; b++) begin
               o_lanes[b] = rotr(i_state[inv_pi_src_row(a, b)][a],
                                 RHO_OFFSET[a][b]);
            end
         end
      end
   end

endmodule

// File: rtl/sha3_inv_rho_pi.sv
// Inverse Keccak rho+pi with sample/good/ack handshake, serial or parallel.
// Define SHA3_INV_RHO_PI_CHECK_EN for the sticky forward-recompute mismatch flag.
module sha3_inv_rho_pi
   import sha3_pkg::*;
#(
   parameter int SERIAL = 1
)(
   input  logic clk,
   input  logic rst,
`ifdef SHA3_INV_RHO_PI_CHECK_EN
   output logic mismatch,
`endif
   input  row_t isa,
   input  row_t isb,
   input  row_t isc,
   input  row_t isd,
   input  row_t ise,
   input  logic sample,
   output logic ready,
   output row_t osa,
   output row_t osb,
   output row_t osc,
   output row_t osd,
   output row_t ose,
   output logic good,
   input  logic ack
);

   state_e     r_state;
   state_e     w_nxt_state;
   logic [2:0] r_row;
   state_t     r_in;
   state_t     r_out;
   state_t     w_next_out;
   logic       w_last;

   generate
      if (SERIAL == 1) begin : g_ser
         row_t w_row;

         sha3_inv_rho_pi_row u_row (
            .i_state (r_in),
            .i_row   (r_row),
            .o_lanes (w_row)
         );

         always_comb begin
            w_next_out        = r_out;
            w_next_out[r_row] = w_row;
         end

         assign w_last = (r_row == 3'd4);
      end else if (SERIAL == 0) begin : g_par
         for (genvar a = 0; a < 5; a++) begin : g_r
            sha3_inv_rho_pi_row u_row (
               .i_state (r_in),
               .i_row   (3'(a)),
               .o_lanes (w_next_out[a])
            );
         end

         assign w_last = 1'b1;
      end else begin : g_bad
         $error("sha3_inv_rho_pi: SERIAL must be 0 or 1");
         assign w_next_out = '0;
         assign w_last     = 1'b0;
      end
   endgenerate

   always_comb begin
      w_nxt_state = r_state;
      case (r_state)
         ST_IDLE: if (sample) w_nxt_state = ST_BUSY;
         ST_BUSY: if (w_last) w_nxt_state = ST_DONE;
         ST_DONE: if (ack)    w_nxt_state = ST_IDLE;
         default:             w_nxt_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_row   <= 3'd0;
         r_in    <= '0;
         r_out   <= '0;
      end else begin
         r_state <= w_nxt_state;
         if (r_state == ST_IDLE && sample) begin
            r_in  <= {ise, isd, isc, isb, isa};
            r_row <= 3'd0;
         end
         if (r_state == ST_BUSY) begin
            r_out <= w_next_out;
            r_row <= w_last ? 3'd0 : r_row + 3'd1;
         end
      end
   end

   assign ready = (r_state == ST_IDLE);
   assign good  = (r_state == ST_DONE);
   assign osa   = r_out[0];
   assign osb   = r_out[1];
   assign osc   = r_out[2];
   assign osd   = r_out[3];
   assign ose   = r_out[4];

`ifdef SHA3_INV_RHO_PI_CHECK_EN
   state_t w_fwd;
   logic   r_mismatch;

   // Forward rho-pi of the result must reproduce the captured input.
   always_comb begin
      w_fwd = '0;
      for (int a = 0; a < 5; a++) begin
         for (int b = 0; b < 5; b++) begin
            w_fwd[(2 * b + 3 * a) % 5][a] =
               rotr(r_out[a][b], (64 - RHO_OFFSET[a][b]) % 64);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_mismatch <= 1'b0;
      end else if (r_state == ST_DONE && w_fwd != r_in) begin
         r_mismatch <= 1'b1;
      end
   end

   assign mismatch = r_mismatch;
`endif

endmodule

// File: tb/tb_sha3_inv_rho_pi.sv
// Directed bench for sha3_inv_rho_pi: serial and parallel instances side by side.
`timescale 1ns/1ps
module tb_sha3_inv_rho_pi;

   typedef logic [4:0][63:0]      rw_t;
   typedef logic [4:0][4:0][63:0] st_t;

   localparam int RT [5][5] = '{
      '{ 0,  1, 62, 28, 27},
      '{36, 44,  6, 55, 20},
      '{ 3, 10, 43, 25, 39},
      '{41, 45, 15, 21,  8},
      '{18,  2, 61, 56, 14}
   };

   logic clk = 1'b0;
   logic rst = 1'b1;
   rw_t  isa, isb, isc, isd, ise;
   logic smp_s, smp_p, ack_s, ack_p;
   logic rdy_s, rdy_p, good_s, good_p;
   rw_t  osa_s, osb_s, osc_s, osd_s, ose_s;
   rw_t  osa_p, osb_p, osc_p, osd_p, ose_p;
`ifdef SHA3_INV_RHO_PI_CHECK_EN
   logic mis_s, mis_p;
`endif

   int n_chk = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   sha3_inv_rho_pi #(.SERIAL(1)) dut_s (
      .clk(clk), .rst(rst),
`ifdef SHA3_INV_RHO_PI_CHECK_EN
      .mismatch(mis_s),
`endif
      .isa(isa), .isb(isb), .isc(isc), .isd(isd), .ise(ise),
      .sample(smp_s), .ready(rdy_s),
      .osa(osa_s), .osb(osb_s), .osc(osc_s), .osd(osd_s), .ose(ose_s),
      .good(good_s), .ack(ack_s)
   );

   sha3_inv_rho_pi #(.SERIAL(0)) dut_p (
      .clk(clk), .rst(rst),
`ifdef SHA3_INV_RHO_PI_CHECK_EN
      .mismatch(mis_p),
`endif
      .isa(isa), .isb(isb), .isc(isc), .isd(isd), .ise(ise),
      .sample(smp_p), .ready(rdy_p),
      .osa(osa_p), .osb(osb_p), .osc(osc_p), .osd(osd_p), .ose(ose_p),
      .good(good_p), .ack(ack_p)
   );

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   task automatic chk_st(input string tag, input st_t got, input st_t exp);
      for (int r = 0; r < 5; r++)
         for (int l = 0; l < 5; l++)
            chk($sformatf("%s[%0d][%0d]", tag, r, l), got[r][l], exp[r][l]);
   endtask

   function automatic logic [63:0] rol(input logic [63:0] x, input int n);
      return (n == 0) ? x : ((x << n) | (x >> (64 - n)));
   endfunction

   // Forward rho-pi: lane b of row a lands in row (2b+3a)%5, lane a.
   function automatic st_t fwd(input st_t v);
      st_t o;
      o = '0;
      for (int a = 0; a < 5; a++)
         for (int b = 0; b < 5; b++)
            o[(2 * b + 3 * a) % 5][a] = rol(v[a][b], RT[a][b]);
      return o;
   endfunction

   function automatic st_t rnd_st();
      st_t s;
      for (int r = 0; r < 5; r++)
         for (int l = 0; l < 5; l++)
            s[r][l] = {$urandom, $urandom};
      return s;
   endfunction

   function automatic st_t get(input bit par);
      st_t g;
      g[0] = par ? osa_p : osa_s;
      g[1] = par ? osb_p : osb_s;
      g[2] = par ? osc_p : osc_s;
      g[3] = par ? osd_p : osd_s;
      g[4] = par ? ose_p : ose_s;
      return g;
   endfunction

   function automatic bit rd(input bit par);
      return par ? rdy_p : rdy_s;
   endfunction

   function automatic bit gd(input bit par);
      return par ? good_p : good_s;
   endfunction

   task automatic drive(input st_t st);
      isa = st[0]; isb = st[1]; isc = st[2]; isd = st[3]; ise = st[4];
   endtask

   task automatic send(input bit par, input st_t st);
      drive(st);
      if (par) smp_p = 1'b1; else smp_s = 1'b1;
      @(negedge clk);
      smp_p = 1'b0;
      smp_s = 1'b0;
   endtask

   task automatic wait_good(input bit par, input int exp_lat, input string tag);
      int n;
      n = 0;
      chk({tag, "_busy_rdy"}, 64'(rd(par)), 64'd0);
      while (!gd(par) && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_lat"}, 64'(n), 64'(exp_lat));
   endtask

   task automatic do_ack(input bit par, input string tag);
      if (par) ack_p = 1'b1; else ack_s = 1'b1;
      @(negedge clk);
      ack_p = 1'b0;
      ack_s = 1'b0;
      chk({tag, "_ack_rdy"}, 64'(rd(par)), 64'd1);
      chk({tag, "_ack_good"}, 64'(gd(par)), 64'd0);
   endtask

   task automatic xact(input bit par, input st_t st, input st_t exp,
                       input string tag);
      send(par, st);
      wait_good(par, par ? 1 : 5, tag);
      chk_st(tag, get(par), exp);
      do_ack(par, tag);
   endtask

   st_t s_in, s_exp, a_st, b_st, c_st;
`ifdef SHA3_INV_RHO_PI_CHECK_EN
   st_t bad_st;
`endif

   initial begin
      smp_s = 1'b0; smp_p = 1'b0; ack_s = 1'b0; ack_p = 1'b0;
      drive('0);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_rdy_s", 64'(rdy_s), 64'd1);
      chk("rst_good_s", 64'(good_s), 64'd0);
      chk("rst_rdy_p", 64'(rdy_p), 64'd1);
      chk("rst_good_p", 64'(good_p), 64'd0);
      chk_st("rst_os_s", get(1'b0), '0);
      rst = 1'b0;
      @(negedge clk);

      // isa[1]=1 -> osb[1] = rotr(1,44)
      s_in = '0;  s_in[0][1] = 64'h1;
      s_exp = '0; s_exp[1][1] = 64'h0000_0000_0010_0000;
      xact(1'b0, s_in, s_exp, "map1_s");
      xact(1'b1, s_in, s_exp, "map1_p");

      // isb[0]=1 -> osa[3] = rotr(1,28)
      s_in = '0;  s_in[1][0] = 64'h1;
      s_exp = '0; s_exp[0][3] = 64'h0000_0010_0000_0000;
      xact(1'b0, s_in, s_exp, "map2_s");
      xact(1'b1, s_in, s_exp, "map2_p");

      for (int i = 0; i < 200; i++) begin
         a_st = rnd_st();
         xact(1'(i % 2), fwd(a_st), a_st, $sformatf("rt%0d", i));
      end
`ifdef SHA3_INV_RHO_PI_CHECK_EN
      chk("rt_mis_s", 64'(mis_s), 64'd0);
      chk("rt_mis_p", 64'(mis_p), 64'd0);
`endif

      // Backpressure: result held while new samples are offered.
      a_st = rnd_st();
      send(1'b0, fwd(a_st));
      wait_good(1'b0, 5, "bp");
      for (int i = 0; i < 10; i++) begin
         drive(fwd(rnd_st()));
         smp_s = 1'b1;
         @(negedge clk);
         chk("bp_rdy", 64'(rdy_s), 64'd0);
         chk("bp_good", 64'(good_s), 64'd1);
      end
      smp_s = 1'b0;
      chk_st("bp_hold", get(1'b0), a_st);
      b_st = rnd_st();
      drive(fwd(b_st));
      smp_s = 1'b1;
      ack_s = 1'b1;
      @(negedge clk);
      smp_s = 1'b0;
      ack_s = 1'b0;
      chk("bpa_good", 64'(good_s), 64'd0);
      chk("bpa_rdy", 64'(rdy_s), 64'd1);
      @(negedge clk);
      chk("bpa_ign_rdy", 64'(rdy_s), 64'd1);
      c_st = rnd_st();
      xact(1'b0, fwd(c_st), c_st, "bp_next");

      // Reset while serial instance is about to write row 2.
      send(1'b0, fwd(rnd_st()));
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("mrst_good", 64'(good_s), 64'd0);
      chk("mrst_rdy", 64'(rdy_s), 64'd1);
      chk_st("mrst_os", get(1'b0), '0);
      rst = 1'b0;
      @(negedge clk);
      c_st = rnd_st();
      xact(1'b0, fwd(c_st), c_st, "mrst_next");

`ifdef SHA3_INV_RHO_PI_CHECK_EN
      a_st = rnd_st();
      send(1'b0, fwd(a_st));
      wait_good(1'b0, 5, "ck");
      bad_st = a_st;
      bad_st[2][3][7] = ~bad_st[2][3][7];
      force dut_s.r_out = bad_st;
      @(negedge clk);
      release dut_s.r_out;
      chk("ck_mis", 64'(mis_s), 64'd1);
      do_ack(1'b0, "ck");
      c_st = rnd_st();
      xact(1'b0, fwd(c_st), c_st, "ck_next");
      chk("ck_mis_sticky", 64'(mis_s), 64'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("ck_mis_rst", 64'(mis_s), 64'd0);
`endif

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule

// File: doc/sha3_inv_rho_pi.md
Name: sha3_inv_rho_pi

Overview:
Inverse of the Keccak rho+pi step: un-permutes lanes and rotates each right by its rho offset, so that feeding this block's output through forward rho-pi returns the original state.
Used by the verification/debug datapath to walk a state back through a round, and by the inverse-permutation path.
Sequential: captures the full 5x5x64 state, then rebuilds it one output row per cycle (or all rows at once), holding the result under a sample/good/ack handshake.

Parameters:
SERIAL, 1, 1 = one output row per cycle (5 compute cycles); 0 = all 25 lanes in one compute cycle; other = $error

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
isa,isb,isc,isd,ise  in  64 x5 each  input state rows 0..4; in[s][c] = row s, lane c
sample  in  1  input valid; accepted only when ready=1
ready  out  1  block idle, sample will be accepted
osa,osb,osc,osd,ose  out  64 x5 each  inverted state rows 0..4; v[a][b]
good  out  1  os* hold a complete result
ack  in  1  consumer takes result; meaningful only when good=1

Behaviour:
- Transform: v[a][b] = rotr(in[s][a], R[a][b]), with s = 2*(b-a) mod 5.
- R[a][b], rows a=0..4, lanes b=0..4:
  - a=0: 0,1,62,28,27
  - a=1: 36,44,6,55,20
  - a=2: 3,10,43,25,39
  - a=3: 41,45,15,21,8
  - a=4: 18,2,61,56,14
- rotr by 0 is identity.
- FSM states IDLE, BUSY, DONE; row counter 3 bits, 0..4.
- IDLE: ready=1, good=0.
  - On an edge with sample=1: capture all 25 input lanes into the input buffer, row<=0, go to BUSY.
- BUSY: ready=0, good=0.
  - SERIAL=1: each edge writes output row `row`, then row++. On the edge that writes row 4, go to DONE.
  - SERIAL=0: one edge writes all 5 rows, then go to DONE.
- DONE: good=1, ready=0, os* stable.
  - On an edge with ack=1, go to IDLE.
- Latency, with sample accepted at edge T:
  - good first visible after edge T+5 (SERIAL=1) or T+1 (SERIAL=0).
  - Minimum sample-to-sample spacing is 7 cycles (SERIAL=1) or 3 cycles (SERIAL=0).
- sample while ready=0: ignored, with no effect on the captured state.
- ack while good=0: ignored.
- ack and sample at the same edge in DONE: ack is honoured and sample is ignored. ready rises the next cycle.
- os* are valid only while good=1. During BUSY they may show a mix of old and new rows.
- Reset, including mid-BUSY or in DONE:
  - state<=IDLE, row<=0, good=0, ready=1 from the first cycle after the reset edge.
  - Output and input buffers clear to 0.
  - Any in-flight computation is discarded.

Optional Feature:
SHA3_INV_RHO_PI_CHECK_EN:
- When defined, adds output port `mismatch` (1 bit, sticky).
- In DONE, forward rho-pi is recomputed on the output buffer and compared with the input buffer. Any difference sets mismatch on the DONE-entry cycle+1.
- mismatch is cleared only by rst.
- When undefined: no port and no compare logic.

Decomposition:
- sha3_pkg: lane_t (64-bit), state_t [5][5] lane_t, RHO_OFFSET[5][5] constant (forward offsets indexed [a][b]), function inv_pi_src_row(a,b) returning 2*(b-a) mod 5.
- Sub-module sha3_inv_rho_pi_row: combinational; takes the captured state and row index a, produces the 5 lanes v[a][0..4].
  - SERIAL=1 instantiates one, muxed by the row counter.
  - SERIAL=0 instantiates five, with constant a.

Test Plan:
- Single-bit map: isa[1]=64'h1, all else 0, sample -> good after 5 cycles (SERIAL=1); osb[1]=64'h0000_0000_0010_0000; all other lanes 0.
- Second map: isb[0]=64'h1 only -> osa[3]=64'h0000_0010_0000_0000, all other lanes 0; repeat with SERIAL=0 -> good after 1 cycle, same data.
- Round trip: 200 random states through the bench's forward rho-pi model, then into this block -> os* equal the original states; mismatch stays 0 with SHA3_INV_RHO_PI_CHECK_EN defined.
- Backpressure: hold ack=0 for 10 cycles in DONE while pulsing sample with new data -> os* unchanged, ready=0, good=1. Then ack=1 together with sample=1 -> next-cycle good=0, ready=1, that sample is ignored.
- Reset mid-operation: rst at BUSY row 2 -> next cycle good=0, ready=1, os*=0. A new sample then completes with the correct result.
- Check feature: force a bit flip in the output buffer in DONE -> mismatch=1 after 1 cycle, and stays 1 across later good transactions until rst.
